sos_sample_feeder: RTL

Upstream stage of the biquad (SOS) filter. Buffers ADC samples that arrive asynchronously to filter readiness in a small synchronous FIFO. Issues one sample_trig per sample to the SOS stage and holds data_in stable through the filter's full 4-cycle computation. Detects FIFO overflow and a stalled filter (missing filter_done).

---
 rtl/sos_sample_feeder_pkg.sv | 24 ++
 rtl/sos_sample_feeder_if.sv | 28 ++
 rtl/sos_sample_feeder_sync_fifo.sv | 62 ++++++
 rtl/sos_sample_feeder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sos_sample_feeder_pkg.sv
// Shared definitions for the SOS sample feeder and the biquad stage benches.
// Holds the feeder FSM encoding and the SOS stage handshake timing constants.
package sos_sample_feeder_pkg;

    // Feeder FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TRIG = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_TRIG = TRIG,
        ST_WAIT = WAIT
    } feeder_state_t;

    // SOS stage handshake: filter_done is high for DONE_PULSES cycles and the
    // stage reads data_in for SOS_CYCLES cycles per sample.
    localparam int unsigned DONE_PULSES = 2;
    localparam int unsigned SOS_CYCLES  = 4;

    // Stall timer width; covers TIMEOUT up to 255
    localparam int unsigned TIMER_BITS = 8;

endpackage

// File: rtl/sos_sample_feeder_if.sv
// Bus between the ADC/control side and the sample feeder, including the SOS
// stage handshake.
//   master : ADC + SOS stage + control (drives samples, filter_done, err_clr)
//   slave  : the feeder (drives filter_data, sample_trig, status)
interface sos_sample_feeder_if #(
    parameter int unsigned DATA_SIZE = 24,
    parameter int unsigned ADDR_BITS = 3
);
    logic [DATA_SIZE-1:0] adc_data;
    logic                 adc_valid;
    logic [DATA_SIZE-1:0] filter_data;
    logic                 sample_trig;
    logic                 filter_done;
    logic [ADDR_BITS:0]   fill_level;
    logic                 overflow;
    logic                 stall_err;
    logic                 err_clr;

    modport master (
        output adc_data, adc_valid, filter_done, err_clr,
        input  filter_data, sample_trig, fill_level, overflow, stall_err
    );

    modport slave (
        input  adc_data, adc_valid, filter_done, err_clr,
        output filter_data, sample_trig, fill_level, overflow, stall_err
    );
endinterface

// File: rtl/sos_sample_feeder_sync_fifo.sv
// Single-clock FIFO with combinational head read and registered occupancy.
// Ports: clk, reset (sync, active-high), wr_en/wr_data, rd_en,
//        rd_data_c (head), count, full_c, empty_c.
// Writes when full and reads when empty are ignored; the caller owns any
// overflow policy.
module sync_fifo #(
    parameter int unsigned DATA_SIZE = 24,
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned DEPTH     = 1 << ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data_c,
    output logic [ADDR_BITS:0]   count,
    output logic                 full_c,
    output logic                 empty_c
);
    localparam int unsigned CNT_BITS = ADDR_BITS + 1;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 do_wr_c;
    logic                 do_rd_c;

    assign full_c    = (count == CNT_BITS'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_wr_c   = wr_en && !full_c;
    assign do_rd_c   = rd_en && !empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Storage needs no reset; only occupied entries are ever read
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at 2**ADDR_BITS
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr_c) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd_c) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr_c && !do_rd_c) begin
                count <= count + 1'b1;
            end else if (do_rd_c && !do_wr_c) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/sos_sample_feeder.sv
// Upstream stage of the biquad (SOS) filter. Queues ADC samples, starts the
// SOS stage with a one-cycle sample_trig per sample and holds filter_data
// stable until the stage reports completion (two filter_done cycles).
// Ports: clk, reset (sync, active-high), bus (slave side):
//   adc_data/adc_valid in, filter_data/sample_trig out, filter_done in,
//   fill_level out, overflow/stall_err sticky out, err_clr in.
module sos_sample_feeder
    import sos_sample_feeder_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 24,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_BITS  = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               reset,
    sos_sample_feeder_if.slave bus
);
    localparam int unsigned DONE_BITS = 2;

    feeder_state_t         state;
    logic [DATA_SIZE-1:0]  head_c;
    logic [DATA_SIZE-1:0]  filter_data_q;
    logic [ADDR_BITS:0]    count;
    logic                  full_c;
    logic                  empty_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  last_done_c;
    logic                  timeout_c;
    logic [DONE_BITS-1:0]  done_cnt;
    logic [TIMER_BITS-1:0] timer;
    logic                  sample_trig_q;
    logic                  overflow_q;
    logic                  stall_err_q;

    // Full is judged on the pre-cycle count, so a same-cycle pop never frees
    // a slot for the incoming sample.
    assign push_c      = bus.adc_valid && !full_c;
    assign pop_c       = (state == ST_IDLE) && !empty_c;
    assign last_done_c = bus.filter_done && (done_cnt == DONE_BITS'(DONE_PULSES - 1));
    assign timeout_c   = (state == ST_WAIT) && !last_done_c
                         && (timer >= TIMER_BITS'(TIMEOUT - 1));

    sync_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_BITS (ADDR_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (push_c),
        .wr_data   (bus.adc_data),
        .rd_en     (pop_c),
        .rd_data_c (head_c),
        .count     (count),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    // Sequencer: pop -> trigger -> wait for the done pair or time out
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            filter_data_q <= '0;
            sample_trig_q <= 1'b0;
            done_cnt      <= '0;
            timer         <= '0;
        end else begin
            sample_trig_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        filter_data_q <= head_c;
                        sample_trig_q <= 1'b1;
                        state         <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    done_cnt <= '0;
                    timer    <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    if (last_done_c || timeout_c) begin
                        state <= ST_IDLE;
                    end else if (bus.filter_done) begin
                        done_cnt <= done_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a same-cycle clear wins over a new event
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            stall_err_q <= 1'b0;
        end else if (bus.err_clr) begin
            overflow_q  <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            if (bus.adc_valid && full_c) begin
                overflow_q <= 1'b1;
            end
            if (timeout_c) begin
                stall_err_q <= 1'b1;
            end
        end
    end

    assign bus.filter_data = filter_data_q;
    assign bus.sample_trig = sample_trig_q;
    assign bus.fill_level  = count;
    assign bus.overflow    = overflow_q;
    assign bus.stall_err   = stall_err_q;
endmodule
